// File: rtl/my_bcs_gate_pkg.sv
// my_bcs_gate_pkg: cascade status type and constants shared by the comparator slice.
// Contents:
//   bcs_status_t  packed {eq, gt} status passed between slices
//   BCS_MSB_IN    cascade-in for the most-significant slice (equal, not greater)
//   BCS_RESET     status held while in reset ("less")
package bcs_pkg;
    typedef struct packed {
        logic eq;
        logic gt;
    } bcs_status_t;
    localparam bcs_status_t BCS_MSB_IN = '{eq: 1'b1, gt: 1'b0};
    localparam bcs_status_t BCS_RESET  = '{eq: 1'b0, gt: 1'b0};
endpackage

// File: rtl/my_bcs_gate_cell.sv
// my_bcs_cell: combinational next-status equations of one comparator bit.
// Ports:
//   a1, b1  in   operand bits at this position
//   e0, g0  in   status from the more-significant slice
//   e1, g1  out  status through this bit (unregistered)
module my_bcs_cell (
    input  logic a1,
    input  logic b1,
    input  logic e0,
    input  logic g0,
    output logic e1,
    output logic g1
);
    logic w_eq;
    assign w_eq = ~(a1 ^ b1);
    assign e1   = e0 & w_eq;
    // e0=g0=1 is not rejected: gt wins and eq still follows the bit compare
    assign g1   = g0 | (e0 & a1 & ~b1);
endmodule

// File: rtl/my_bcs_gate.sv
// my_bcs_gate: one-bit cascadable magnitude-comparator slice, optionally registered.
// Parameters:
//   REG_OUT  1: e1/g1 registered (1-cycle latency); 0: combinational, clk/rst_n unused
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset, forces e1=g1=0
//   a1, b1  in   operand bits at this position
//   e0, g0  in   cascade-in: higher bits equal / A already greater
//   e1, g1  out  cascade-out: A==B / A>B through this bit
module my_bcs_gate
    import bcs_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a1,
    input  logic b1,
    input  logic e0,
    input  logic g0,
    output logic e1,
    output logic g1
);
    bcs_status_t w_nx;

    my_bcs_cell u_cell (
        .a1(a1),
        .b1(b1),
        .e0(e0),
        .g0(g0),
        .e1(w_nx.eq),
        .g1(w_nx.gt)
    );

    generate
        if (REG_OUT) begin : g_reg
            bcs_status_t r_st;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_st <= BCS_RESET;
                else        r_st <= w_nx;
            end
            assign e1 = r_st.eq;
            assign g1 = r_st.gt;
        end else begin : g_comb
            assign e1 = w_nx.eq;
            assign g1 = w_nx.gt;
        end
    endgenerate
endmodule

// File: tb/tb_my_bcs_gate.sv
// tb_my_bcs_gate: scoreboard bench for the registered slice, combinational slice and a 4-bit chain.
module tb_my_bcs_gate;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a1 = 1'b0, b1 = 1'b0, e0 = 1'b0, g0 = 1'b0;
    logic e1, g1, ce1, cg1;
    logic [3:0] ca = 4'd0, cb = 4'd0;
    wire  [4:0] ke, kg;
    logic [1:0] q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    my_bcs_gate #(.REG_OUT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .b1(b1), .e0(e0), .g0(g0), .e1(e1), .g1(g1)
    );

    my_bcs_gate #(.REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .a1(a1), .b1(b1), .e0(e0), .g0(g0), .e1(ce1), .g1(cg1)
    );

    assign ke[4] = 1'b1;
    assign kg[4] = 1'b0;
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_chain
            my_bcs_gate #(.REG_OUT(1'b0)) u_s (
                .clk(clk), .rst_n(rst_n), .a1(ca[i]), .b1(cb[i]), .e0(ke[i+1]), .g0(kg[i+1]),
                .e1(ke[i]), .g1(kg[i])
            );
        end
    endgenerate

    // Reference: status as a relation; greater if already greater or this bit decides it.
    function automatic logic [1:0] ref_slice(input logic a, b, e, g);
        logic eq, gt;
        eq = e && (a == b);
        gt = g || (e && (a > b));
        return {eq, gt};
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got e1g1=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic a, b, e, g);
        @(negedge clk);
        a1 = a; b1 = b; e0 = e; g0 = g;
        q.push_back(ref_slice(a, b, e, g));
        #1 check("comb", {ce1, cg1}, ref_slice(a, b, e, g));
    endtask

    task automatic chain(input logic [3:0] a, b);
        ca = a; cb = b;
        #1 check("chain", {ke[0], kg[0]}, {a == b, a > b});
    endtask

    initial begin : monitor
        logic [1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp = q.pop_front();
                check("reg", {e1, g1}, exp);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        a1 = 1'b1; b1 = 1'b0; e0 = 1'b1; g0 = 1'b1;
        #2 check("reset_async", {e1, g1}, 2'b00);
        repeat (3) @(posedge clk);
        #1 check("reset_hold", {e1, g1}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) apply(k[3], k[2], k[1], k[0]);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) apply(k[1], k[0], 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) apply(k[1], k[0], 1'b0, 1'b0);
        repeat (150) apply($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2 check("pre_reset", {e1, g1}, 2'b01);
        rst_n = 1'b0;
        #1 check("midrun_reset_async", {e1, g1}, 2'b00);
        @(posedge clk);
        #1 check("midrun_reset_hold", {e1, g1}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(2'b01);
        @(negedge clk);
        chain(4'b1010, 4'b1010);
        chain(4'b1011, 4'b1010);
        chain(4'b0111, 4'b1000);
        chain(4'b0000, 4'b1111);
        chain(4'b1111, 4'b1111);
        repeat (60) chain(4'($urandom_range(15)), 4'($urandom_range(15)));
        repeat (3) @(posedge clk);
        #2 check("queue_drained", 2'(q.size()), 2'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
